// File: rtl/stream_splitter.sv
// ---------------------------------------------------------------------------
// stream_splitter
//
// Purpose:
//   Fans one valid/ready input stream out to three output lanes. Each accepted
//   word goes to the lane named by its per-word select. Every lane has its own
//   small FIFO, so a stalled lane only blocks the input once its FIFO is full.
//
// Configuration macro:
//   SPLIT_BCAST_EN  defined   : in_sel == 3 broadcasts the word to all three
//                               lanes. It is accepted only when no lane is full.
//                   undefined : in_sel == 3 is illegal. The word is accepted and
//                               dropped, err_sel pulses for one cycle and
//                               drop_cnt counts up, saturating at 255.
//
// Parameters:
//   W       data width of the input and of each lane
//   DEPTH   entries per lane FIFO (power of two, >= 2)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   input word present
//   in_ready   input word accepted when in_valid && in_ready (combinational)
//   in_data    input word
//   in_sel     target lane 0..2, 3 = broadcast or illegal
//   out_valid  per-lane "FIFO not empty"
//   out_ready  per-lane consumer ready
//   out_data   lane i head word in bits [i*W +: W]
//   err_sel    one-cycle pulse after an illegal select is accepted
//   drop_cnt   saturating count of dropped words
// ---------------------------------------------------------------------------
module stream_splitter #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_data,
    input  logic [1:0]     in_sel,
    output logic [2:0]     out_valid,
    input  logic [2:0]     out_ready,
    output logic [3*W-1:0] out_data,
    output logic           err_sel,
    output logic [7:0]     drop_cnt
);

    localparam int LANES = 3;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_r      [LANES][DEPTH];
    logic [AW-1:0] wr_ptr_r   [LANES];
    logic [AW-1:0] rd_ptr_r   [LANES];
    logic [CW-1:0] count_r    [LANES];
    logic [W-1:0]  head_r     [LANES];
    logic [2:0]    valid_r;
    logic          err_r;
    logic [7:0]    drop_r;

    logic [AW-1:0] next_rd_s  [LANES];
    logic [CW-1:0] next_cnt_s [LANES];
    logic [W-1:0]  next_head_s[LANES];
    logic [2:0]    full_s;
    logic [2:0]    push_s;
    logic [2:0]    pop_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          bcast_s;
    logic          drop_s;

    // Per-lane full flags straight from the occupancy counters.
    always_comb begin
        full_s = 3'b000;
        for (int i = 0; i < LANES; i++) begin
            full_s[i] = (count_r[i] == FULL_CNT);
        end
    end

    // Input readiness depends only on the select and the lane occupancy; a
    // full lane refuses a word even in a cycle where it is popping.
    always_comb begin
        in_ready_s = 1'b0;
        case (in_sel)
            2'd0:    in_ready_s = ~full_s[0];
            2'd1:    in_ready_s = ~full_s[1];
            2'd2:    in_ready_s = ~full_s[2];
            2'd3: begin
`ifdef SPLIT_BCAST_EN
                in_ready_s = ~(|full_s);
`else
                in_ready_s = 1'b1;
`endif
            end
            default: in_ready_s = 1'b0;
        endcase
    end

    // Decode the accepted word into per-lane pushes or the drop path.
    always_comb begin
        accept_s = in_valid & in_ready_s;
`ifdef SPLIT_BCAST_EN
        bcast_s  = (in_sel == 2'd3);
        drop_s   = 1'b0;
`else
        bcast_s  = 1'b0;
        drop_s   = accept_s & (in_sel == 2'd3);
`endif
        push_s = 3'b000;
        pop_s  = 3'b000;
        for (int i = 0; i < LANES; i++) begin
            push_s[i] = accept_s & ((in_sel == 2'(i)) | bcast_s);
            pop_s[i]  = valid_r[i] & out_ready[i];
        end
    end

    // Next read pointer, occupancy and head word of every lane. The pushed
    // word lands at the head only when it lands at the new read pointer,
    // which happens exactly when the lane holds one word afterwards.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            next_rd_s[i]   = rd_ptr_r[i] + AW'(pop_s[i]);
            next_cnt_s[i]  = count_r[i] + CW'(push_s[i]) - CW'(pop_s[i]);
            next_head_s[i] = head_r[i];
            if (next_cnt_s[i] == {CW{1'b0}}) begin
                next_head_s[i] = head_r[i];
            end else if (push_s[i] && (wr_ptr_r[i] == next_rd_s[i])) begin
                next_head_s[i] = in_data;
            end else begin
                next_head_s[i] = mem_r[i][next_rd_s[i]];
            end
        end
    end

    // Lane FIFO storage, pointers, counters and registered head/valid outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    mem_r[i][j] <= {W{1'b0}};
                end
                wr_ptr_r[i] <= {AW{1'b0}};
                rd_ptr_r[i] <= {AW{1'b0}};
                count_r[i]  <= {CW{1'b0}};
                head_r[i]   <= {W{1'b0}};
            end
            valid_r <= 3'b000;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if (push_s[i]) begin
                    mem_r[i][wr_ptr_r[i]] <= in_data;
                    wr_ptr_r[i]           <= wr_ptr_r[i] + AW'(1);
                end else begin
                    wr_ptr_r[i] <= wr_ptr_r[i];
                end
                rd_ptr_r[i] <= next_rd_s[i];
                count_r[i]  <= next_cnt_s[i];
                head_r[i]   <= next_head_s[i];
                valid_r[i]  <= (next_cnt_s[i] != {CW{1'b0}});
            end
        end
    end

    // Illegal-select error pulse and saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_r  <= 1'b0;
            drop_r <= 8'd0;
        end else begin
            err_r <= drop_s;
            if (drop_s && (drop_r != 8'hFF)) begin
                drop_r <= drop_r + 8'd1;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    // Port mapping; all outputs except in_ready come straight from registers.
    always_comb begin
        in_ready  = in_ready_s;
        out_valid = valid_r;
        err_sel   = err_r;
        drop_cnt  = drop_r;
        out_data  = {(3*W){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            out_data[i*W +: W] = head_r[i];
        end
    end

endmodule
